// File: rtl/pipe_pkg.sv
// Shared definitions for the pipelined MIPS control path.
// Contents:
//   - opcode constants for the decoded instruction subset
//   - ALU-op, PC-select and forwarding-select encodings
//   - ctrl_t, the decoded control bundle produced in ID
package pipe_pkg;

  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_ADDI  = 2'b11;

  localparam logic [1:0] PCSRC_SEQ    = 2'b00;
  localparam logic [1:0] PCSRC_BRANCH = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  typedef struct packed {
    logic       alu_src;
    logic [1:0] alu_op;
    logic       mem_read;
    logic       mem_write;
    logic       branch;
    logic       jump;
    logic       reg_write;
    logic       mem_to_reg;
  } ctrl_t;

endpackage

// File: rtl/pipe_ctrl_main_dec.sv
// Main decoder: combinational opcode -> control bundle for the ID stage.
// Ports:
//   opcode   in   OPCODE_W  instruction opcode field
//   ctrl     out  ctrl_t    decoded control flags (all zero for unknown opcodes)
//   usesRs   out  1         instruction reads rs
//   usesRt   out  1         instruction reads rt
//   destIsRd out  1         destination is rd (otherwise rt)
module main_dec
  import pipe_pkg::*;
#(
  parameter int OPCODE_W = 6
) (
  input  logic [OPCODE_W-1:0] opcode,
  output ctrl_t               ctrl,
  output logic                usesRs,
  output logic                usesRt,
  output logic                destIsRd
);

  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves
    // a signal unassigned, which would otherwise infer a latch.
    ctrl     = '0;
    usesRs   = 1'b0;
    usesRt   = 1'b0;
    destIsRd = 1'b0;
    case (opcode)
      OP_LW: begin
        ctrl.alu_src    = 1'b1;
        ctrl.alu_op     = ALUOP_ADD;
        ctrl.mem_read   = 1'b1;
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        usesRs          = 1'b1;
      end
      OP_SW: begin
        ctrl.alu_src   = 1'b1;
        ctrl.alu_op    = ALUOP_ADD;
        ctrl.mem_write = 1'b1;
        usesRs         = 1'b1;
        usesRt         = 1'b1;
      end
      OP_BEQ: begin
        ctrl.branch = 1'b1;
        ctrl.alu_op = ALUOP_SUB;
        usesRs      = 1'b1;
        usesRt      = 1'b1;
      end
      OP_RTYPE: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_op    = ALUOP_FUNCT;
        usesRs         = 1'b1;
        usesRt         = 1'b1;
        destIsRd       = 1'b1;
      end
      OP_J: begin
        ctrl.jump = 1'b1;
      end
      OP_ADDI: begin
        ctrl.alu_src   = 1'b1;
        ctrl.alu_op    = ALUOP_ADDI;
        ctrl.reg_write = 1'b1;
        usesRs         = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipelined control for the 5-stage MIPS core: ID decode, ID/EX, EX/MEM and
// MEM/WB control registers, hazard stalls, branch/jump flushes, PC select
// and EX-stage forwarding selects.
// Ports:
//   clk, reset                     rising-edge clock, synchronous active-high reset
//   id_opcode/id_rs/id_rt/id_rd    instruction fields held in IF/ID
//   mem_zero                       ALU zero flag from EX/MEM
//   pc_write, if_id_write          PC / IF/ID load enables
//   if_id_flush                    clear IF/ID to a NOP
//   pc_src                         00 PC+4, 01 branch target, 10 jump target
//   ex_alu_src, ex_alu_op          EX-stage ALU controls
//   mem_read, mem_write            MEM-stage data-memory controls
//   wb_reg_write, wb_mem_to_reg    WB-stage controls
//   wb_dest                        WB register index
//   fwd_a, fwd_b                   EX operand selects: 00 regfile, 01 WB, 10 MEM
module pipe_ctrl
  import pipe_pkg::*;
#(
  parameter int REG_ADDR_W = 5,
  parameter int OPCODE_W   = 6,
  parameter int FWD_EN     = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [OPCODE_W-1:0]   id_opcode,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  mem_zero,
  output logic                  pc_write,
  output logic                  if_id_write,
  output logic                  if_id_flush,
  output logic [1:0]            pc_src,
  output logic                  ex_alu_src,
  output logic [1:0]            ex_alu_op,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic                  wb_reg_write,
  output logic                  wb_mem_to_reg,
  output logic [REG_ADDR_W-1:0] wb_dest,
  output logic [1:0]            fwd_a,
  output logic [1:0]            fwd_b
);

  typedef logic [REG_ADDR_W-1:0] regIdx_t;

  // Dest is zero for non-writing instructions, so a nonzero dest alone
  // identifies a pending register write in every stage.
  typedef struct packed {
    logic       aluSrc;
    logic [1:0] aluOp;
    logic       memRead;
    logic       memWrite;
    logic       branch;
    logic       regWrite;
    logic       memToReg;
    regIdx_t    rs;
    regIdx_t    rt;
    regIdx_t    dest;
  } idEx_t;

  typedef struct packed {
    logic    memRead;
    logic    memWrite;
    logic    branch;
    logic    regWrite;
    logic    memToReg;
    regIdx_t dest;
  } exMem_t;

  typedef struct packed {
    logic    regWrite;
    logic    memToReg;
    regIdx_t dest;
  } memWb_t;

  ctrl_t  idCtrl;
  logic   idUsesRs, idUsesRt, idDestIsRd;
  idEx_t  idEx, idExNext;
  exMem_t exMem, exMemNext;
  memWb_t memWb, memWbNext;
  logic   loadUse, rawHazard, stall, branchTaken;

  main_dec #(.OPCODE_W(OPCODE_W)) uDec (
    .opcode   (id_opcode),
    .ctrl     (idCtrl),
    .usesRs   (idUsesRs),
    .usesRt   (idUsesRt),
    .destIsRd (idDestIsRd)
  );

  // True when a stage writing `dest` feeds a source the ID instruction reads.
  function automatic logic readsReg(input regIdx_t dest, input regIdx_t rs,
                                    input regIdx_t rt, input logic usesRs,
                                    input logic usesRt);
    return (dest != '0) && ((usesRs && rs == dest) || (usesRt && rt == dest));
  endfunction

  function automatic logic [1:0] fwdSel(input regIdx_t src, input exMem_t m,
                                        input memWb_t w);
    if (m.regWrite && m.dest != '0 && m.dest == src) return FWD_MEM;
    if (w.regWrite && w.dest != '0 && w.dest == src) return FWD_WB;
    return FWD_REG;
  endfunction

  assign loadUse = idEx.memRead &&
                   readsReg(idEx.dest, id_rs, id_rt, idUsesRs, idUsesRt);
  // WB needs no check: the register file writes before it reads.
  assign rawHazard = readsReg(idEx.dest, id_rs, id_rt, idUsesRs, idUsesRt) ||
                     readsReg(exMem.dest, id_rs, id_rt, idUsesRs, idUsesRt);
  assign stall       = loadUse || ((FWD_EN == 0) && rawHazard);
  assign branchTaken = exMem.branch && mem_zero;

  // PC / IF-ID control. A taken branch outranks a stall or a jump in ID.
  always_comb begin
    pc_write    = 1'b0;
    if_id_write = 1'b0;
    if_id_flush = 1'b0;
    pc_src      = PCSRC_SEQ;
    if (!reset) begin
      if (branchTaken) begin
        pc_write    = 1'b1;
        if_id_write = 1'b1;
        if_id_flush = 1'b1;
        pc_src      = PCSRC_BRANCH;
      end else if (!stall) begin
        pc_write    = 1'b1;
        if_id_write = 1'b1;
        if (idCtrl.jump) begin
          if_id_flush = 1'b1;
          pc_src      = PCSRC_JUMP;
        end
      end
    end
  end

  // Next stage contents. Stalled, flushed and jump instructions enter EX as bubbles.
  always_comb begin
    idExNext = '0;
    if (!(stall || branchTaken || idCtrl.jump)) begin
      idExNext.aluSrc   = idCtrl.alu_src;
      idExNext.aluOp    = idCtrl.alu_op;
      idExNext.memRead  = idCtrl.mem_read;
      idExNext.memWrite = idCtrl.mem_write;
      idExNext.branch   = idCtrl.branch;
      idExNext.regWrite = idCtrl.reg_write;
      idExNext.memToReg = idCtrl.mem_to_reg;
      idExNext.rs       = id_rs;
      idExNext.rt       = id_rt;
      idExNext.dest     = idCtrl.reg_write ? (idDestIsRd ? id_rd : id_rt) : '0;
    end

    exMemNext = '0;
    if (!branchTaken) begin
      exMemNext.memRead  = idEx.memRead;
      exMemNext.memWrite = idEx.memWrite;
      exMemNext.branch   = idEx.branch;
      exMemNext.regWrite = idEx.regWrite;
      exMemNext.memToReg = idEx.memToReg;
      exMemNext.dest     = idEx.dest;
    end

    memWbNext.regWrite = exMem.regWrite;
    memWbNext.memToReg = exMem.memToReg;
    memWbNext.dest     = exMem.dest;
  end

  // NOTE: state registers use non-blocking assignments so every stage samples
  // its predecessor's pre-edge value; reset clears them all to a bubble
  // because the hazard logic trusts stage contents from the first cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      idEx  <= '0;
      exMem <= '0;
      memWb <= '0;
    end else begin
      idEx  <= idExNext;
      exMem <= exMemNext;
      memWb <= memWbNext;
    end
  end

  always_comb begin
    fwd_a = FWD_REG;
    fwd_b = FWD_REG;
    if ((FWD_EN != 0) && !reset) begin
      fwd_a = fwdSel(idEx.rs, exMem, memWb);
      fwd_b = fwdSel(idEx.rt, exMem, memWb);
    end
  end

  assign ex_alu_src    = idEx.aluSrc;
  assign ex_alu_op     = idEx.aluOp;
  assign mem_read      = exMem.memRead;
  assign mem_write     = exMem.memWrite;
  assign wb_reg_write  = memWb.regWrite;
  assign wb_mem_to_reg = memWb.memToReg;
  assign wb_dest       = memWb.dest;

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Pipelined successor to the single-cycle main control decoder, for the 5-stage MIPS core.
- Decodes the ID-stage opcode for lw, sw, beq, R-type, j and addi.
- Carries the control bits through the ID/EX, EX/MEM and MEM/WB stage registers, with destination-register tracking.
- Generates load-use/RAW stalls, branch/jump flushes, PC select and EX-stage forwarding selects.

Parameters:
- REG_ADDR_W, 5, register-index width.
- OPCODE_W, 6, opcode width.
- FWD_EN, 1, 1 = forwarding enabled, stall only on load-use; 0 = no forwarding, stall on any RAW hazard against EX or MEM.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- id_opcode  in  OPCODE_W  instr[31:26] held in IF/ID.
- id_rs  in  REG_ADDR_W  instr[25:21].
- id_rt  in  REG_ADDR_W  instr[20:16].
- id_rd  in  REG_ADDR_W  instr[15:11].
- mem_zero  in  1  ALU zero flag registered in EX/MEM.
- pc_write  out  1  PC load enable.
- if_id_write  out  1  IF/ID load enable.
- if_id_flush  out  1  clear IF/ID to NOP.
- pc_src  out  2  00 PC+4, 01 branch target, 10 jump target.
- ex_alu_src  out  1  ALU B operand from immediate.
- ex_alu_op  out  2  00 add, 01 sub, 10 funct, 11 addi.
- mem_read  out  1  data-memory read.
- mem_write  out  1  data-memory write.
- wb_reg_write  out  1  register-file write.
- wb_mem_to_reg  out  1  write-back from memory.
- wb_dest  out  REG_ADDR_W  write-back register index.
- fwd_a  out  2  EX operand A select: 00 regfile, 01 WB, 10 MEM.
- fwd_b  out  2  EX operand B select, same encoding.

Behaviour:
- Decode is combinational in ID. All flags are active-high, including jump.
  - lw: alu_src, mem_to_reg, reg_write, mem_read; aluop 00; dest rt.
  - sw: alu_src, mem_write; aluop 00.
  - beq: branch; aluop 01.
  - R-type: reg_write; aluop 10; dest rd.
  - j: jump.
  - addi: alu_src, reg_write; aluop 11; dest rt.
  - Any other opcode: all zero.
- Source usage:
  - R-type, sw, beq read rs and rt.
  - lw, addi read rs only.
  - j and unknown opcodes read nothing.
- Stage registers:
  - ID/EX holds controls, rs, rt and dest. Dest is 0 when the instruction does not write.
  - EX/MEM holds mem_read, mem_write, branch, reg_write, mem_to_reg, dest.
  - MEM/WB holds reg_write, mem_to_reg, dest.
  - Every register updates each clk.
- Reset: all stage registers clear to a bubble (all zero). While reset is high, pc_write=0, if_id_write=0, if_id_flush=0, pc_src=00, fwd_a=fwd_b=00. The cycle after reset: pc_write=1, if_id_write=1.
- Hazard conditions:
  - load-use: ex_mem_read and ex_dest≠0 and ex_dest matches a used ID source.
  - FWD_EN=0 only: also stall when ex_reg_write or mem_reg_write has a nonzero dest matching a used ID source.
  - The register file is write-first, so WB never needs a stall.
- Stall action: pc_write=0, if_id_write=0, bubble into ID/EX. EX/MEM and MEM/WB advance.
- Branch taken (mem_branch and mem_zero):
  - pc_src=01, pc_write=1, if_id_flush=1.
  - Bubble into ID/EX and EX/MEM.
  - Overrides any stall or jump in the same cycle.
- Jump in ID with no branch taken and no stall:
  - pc_src=10, if_id_flush=1. The jump itself proceeds as a bubble (no controls).
  - A jump never stalls, since it has no sources.
- Forwarding:
  - FWD_EN=1: fwd_a=10 if mem_reg_write and mem_dest≠0 and mem_dest==ex_rs. Otherwise 01 if the same holds for WB. Otherwise 00. MEM has priority over WB.
  - fwd_b uses the same rule on ex_rt.
  - FWD_EN=0: fwd_a and fwd_b are tied to 00.
- Register $0 never triggers a hazard or forward.

Decomposition:
- Shared package pipe_pkg:
  - opcode constants OP_LW=100011, OP_SW=101011, OP_BEQ=000100, OP_RTYPE=000000, OP_J=000010, OP_ADDI=001000;
  - ALUOP_* codes, PCSRC_*, FWD_* encodings;
  - a ctrl_t struct {alu_src, alu_op, mem_read, mem_write, branch, jump, reg_write, mem_to_reg}.
- One sub-module, main_dec: combinational opcode → ctrl_t plus uses_rs/uses_rt/dest_is_rd.
- Hazard, forwarding and the stage registers stay in pipe_ctrl.

Test Plan:
- Back-to-back lw $2,0($1); add $3,$2,$4 with FWD_EN=1 → one stall cycle (pc_write=0, if_id_write=0, bubble in EX); then fwd_a=01 when add reaches EX.
- add $2,$1,$1; sub $5,$2,$2 with FWD_EN=1 → no stall; fwd_a=fwd_b=10 in sub's EX cycle. With FWD_EN=0 → two stall cycles, fwd=00.
- beq in MEM with mem_zero=1 while lw-use is pending in ID → pc_src=01, if_id_flush=1, EX/MEM and ID/EX bubbled, no stall.
- j in ID → pc_src=10, if_id_flush=1 for one cycle; no write controls reach WB.
- add $0,$1,$1 followed by use of $0 → no forward, no stall; unknown opcode 111111 → all controls zero at WB.
- Assert reset mid-stream with a lw in MEM → next cycle wb_reg_write=0, mem_read=0, pc_write=1 after release.
